// File: rtl/stage_pipeline.sv
// rtl/stage_pipeline.sv - valid/ready stage pipeline with per-stage flush and global freeze
module stage_pipeline #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    input  logic [DEPTH-1:0] flush,
    input  logic             freeze,
    output logic [CW-1:0]    count
);

    // Stage 0 is the input side, stage DEPTH-1 drives the output.
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];

    logic [DEPTH-1:0] lv;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] src_data [DEPTH];

    // A flushed entry is dead this cycle: never forwarded and never presented.
    assign lv = v & ~flush;

    // Advance enables ripple from the output end: a stage moves when it is
    // empty (or dead) or when the stage downstream of it moves.
    always_comb begin
        logic carry;
        carry = out_ready & ~freeze;
        adv   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            carry  = ~freeze & (~lv[k] | carry);
            adv[k] = carry;
        end
    end

    // Each stage loads from its upstream neighbour; stage 0 loads from the port.
    always_comb begin
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int k = 1; k < DEPTH; k++) begin
            src_valid[k] = lv[k-1];
            src_data[k]  = d[k-1];
        end
    end

    // Stage registers: shift on advance, otherwise hold while letting flush clear the valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                d[k] <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v[k] <= src_valid[k];
                    // Data only moves with a live entry so a bubble leaves the old payload.
                    if (src_valid[k]) begin
                        d[k] <= src_data[k];
                    end
                end else begin
                    v[k] <= lv[k];
                end
            end
        end
    end

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        count = '0;
        for (int k = 0; k < DEPTH; k++) begin
            count = count + CW'(v[k]);
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = lv[DEPTH-1] & ~freeze;
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_stage_pipeline.sv
// tb/tb_stage_pipeline.sv - scoreboard bench for stage_pipeline (DEPTH=4 and DEPTH=1 builds)
module tb_stage_pipeline;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [W-1:0]  in_data;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic          out_ready;
    logic [D-1:0]  flush;
    logic          freeze;
    logic [CW-1:0] count;

    logic          o_in_valid;
    logic [W-1:0]  o_in_data;
    logic          o_in_ready;
    logic          o_out_valid;
    logic [W-1:0]  o_out_data;
    logic          o_out_ready;
    logic [0:0]    o_flush;
    logic          o_freeze;
    logic [0:0]    o_count;

    int            passed = 0;
    int            total  = 0;
    logic [W-1:0]  exp_q[$];
    logic [W-1:0]  exp_v;

    always #5 clk = ~clk;

    stage_pipeline #(.WIDTH(W), .DEPTH(D), .CW(CW)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .flush     (flush),
        .freeze    (freeze),
        .count     (count)
    );

    stage_pipeline #(.WIDTH(W), .DEPTH(1), .CW(1)) u_one (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (o_in_valid),
        .in_data   (o_in_data),
        .in_ready  (o_in_ready),
        .out_valid (o_out_valid),
        .out_data  (o_out_data),
        .out_ready (o_out_ready),
        .flush     (o_flush),
        .freeze    (o_freeze),
        .count     (o_count)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %0b want 0", out_valid); else passed++;
        total++; if (out_data !== '0) $display("FAIL rst_out_data: got %0h want 0", out_data); else passed++;
        total++; if (count !== '0) $display("FAIL rst_count: got %0d want 0", count); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %0b want 1", in_ready); else passed++;
        freeze = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_frozen: got %0b want 0", in_ready); else passed++;
        freeze = 1'b0;
        in_valid = 1'b1;
        in_data = 32'h55;
        tick();
        total++; if (count !== '0) $display("FAIL rst_no_capture: got %0d want 0", count); else passed++;
        total++; if (o_count !== 1'b0 || o_out_valid !== 1'b0) $display("FAIL rst_d1: got cnt=%0d ov=%0b want 0/0", o_count, o_out_valid); else passed++;
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        total++; if (count !== '0 || out_valid !== 1'b0) $display("FAIL rst_after: got cnt=%0d ov=%0b want 0/0", count, out_valid); else passed++;
    endtask

    task automatic test_stream;
        int acc_first = -1;
        int out_first = -1;
        int out_last  = -1;
        int n_out     = 0;
        int peak      = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            in_valid = (i < 3);
            in_data  = 32'h100 + 32'(4 * i);
            @(negedge clk);
            if (int'(count) > peak) peak = int'(count);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                if (acc_first < 0) acc_first = i;
            end
            if (out_valid && out_ready) begin
                if (out_first < 0) out_first = i;
                out_last = i;
                n_out++;
                total++;
                if (exp_q.size() == 0) $display("FAIL stream_data: got unexpected %0h want none", out_data);
                else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) $display("FAIL stream_data: got %0h want %0h", out_data, exp_v); else passed++;
                end
            end
            tick();
        end
        in_valid = 1'b0;
        total++; if (out_first - acc_first !== 4) $display("FAIL stream_latency: got %0d want 4", out_first - acc_first); else passed++;
        total++; if (n_out !== 3 || out_last - out_first !== 2) $display("FAIL stream_throughput: got n=%0d span=%0d want 3/2", n_out, out_last - out_first); else passed++;
        total++; if (peak !== 3) $display("FAIL stream_peak_count: got %0d want 3", peak); else passed++;
        total++; if (exp_q.size() !== 0) $display("FAIL stream_drained: got %0d left want 0", exp_q.size()); else passed++;
    endtask

    task automatic test_backpressure;
        int idx   = 0;
        int n_out = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hC0 + 32'(4 * idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                idx++;
            end
            tick();
        end
        total++; if (idx !== 4) $display("FAIL bp_accepted: got %0d want 4", idx); else passed++;
        total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %0b want 0", in_ready); else passed++;
        total++; if (count !== 3'd4) $display("FAIL bp_count: got %0d want 4", count); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_valid = (idx < 6);
            in_data  = 32'hC0 + 32'(4 * idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                idx++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) $display("FAIL bp_data: got unexpected %0h want none", out_data);
                else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) $display("FAIL bp_data: got %0h want %0h", out_data, exp_v); else passed++;
                end
            end
            tick();
            if (idx == 6 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        total++; if (n_out !== 6) $display("FAIL bp_drain: got %0d outputs want 6", n_out); else passed++;
    endtask

    task automatic test_flush;
        int idx   = 0;
        int n_out = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10 && idx < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 32'hA0 + 32'(4 * idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                idx++;
            end
            tick();
        end
        total++; if (count !== 3'd4) $display("FAIL flush_full: got %0d want 4", count); else passed++;
        flush    = 4'b0011;
        in_valid = 1'b1;
        in_data  = 32'hB0;
        @(negedge clk);
        total++; if (in_ready !== 1'b1) $display("FAIL flush_refill_ready: got %0b want 1", in_ready); else passed++;
        if (in_valid && in_ready) begin
            // stages 0 and 1 hold the two newest entries (0xAC, 0xA8)
            void'(exp_q.pop_back());
            void'(exp_q.pop_back());
            exp_q.push_back(in_data);
        end
        tick();
        flush    = '0;
        in_valid = 1'b0;
        total++; if (count !== 3'd3) $display("FAIL flush_count: got %0d want 3", count); else passed++;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            if (out_valid && out_ready) begin
                n_out++;
                total++;
                exp_v = exp_q.pop_front();
                if (out_data !== exp_v) $display("FAIL flush_data: got %0h want %0h", out_data, exp_v); else passed++;
            end
            tick();
        end
        tick();
        total++; if (n_out !== 3 || out_valid !== 1'b0) $display("FAIL flush_drain: got n=%0d ov=%0b want 3/0", n_out, out_valid); else passed++;
    endtask

    task automatic test_freeze;
        int idx   = 0;
        int n_out = 0;
        logic [CW-1:0] frz_count;
        frz_count = '0;
        out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            freeze   = (c >= 4 && c < 7);
            in_valid = (idx < 8);
            in_data  = 32'h200 + 32'(4 * idx);
            @(negedge clk);
            if (c == 4) frz_count = count;
            if (freeze) begin
                total++; if (in_ready !== 1'b0) $display("FAIL freeze_in_ready: got %0b want 0", in_ready); else passed++;
                total++; if (out_valid !== 1'b0) $display("FAIL freeze_out_valid: got %0b want 0", out_valid); else passed++;
                if (c > 4) begin
                    total++; if (count !== frz_count) $display("FAIL freeze_count: got %0d want %0d", count, frz_count); else passed++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                idx++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) $display("FAIL freeze_data: got unexpected %0h want none", out_data);
                else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) $display("FAIL freeze_data: got %0h want %0h", out_data, exp_v); else passed++;
                end
            end
            tick();
            if (idx == 8 && exp_q.size() == 0) break;
        end
        freeze   = 1'b0;
        in_valid = 1'b0;
        total++; if (n_out !== 8) $display("FAIL freeze_total: got %0d outputs want 8", n_out); else passed++;
    endtask

    task automatic test_reset_midstream;
        int idx   = 0;
        int n_out = 0;
        out_ready = 1'b0;
        for (int i = 0; i < 10 && idx < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h300 + 32'(4 * idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                idx++;
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        total++; if (count !== 3'd3 || out_valid !== 1'b1) $display("FAIL rstmid_before: got cnt=%0d ov=%0b want 3/1", count, out_valid); else passed++;
        #3;
        rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0 || count !== '0) $display("FAIL rstmid_async: got ov=%0b cnt=%0d want 0/0", out_valid, count); else passed++;
        total++; if (out_data !== '0) $display("FAIL rstmid_data: got %0h want 0", out_data); else passed++;
        exp_q.delete();
        #2;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        idx = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (idx < 2);
            in_data  = 32'h3A0 + 32'(4 * idx);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                idx++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                total++;
                if (exp_q.size() == 0) $display("FAIL rstmid_data_out: got stale %0h want none", out_data);
                else begin
                    exp_v = exp_q.pop_front();
                    if (out_data !== exp_v) $display("FAIL rstmid_data_out: got %0h want %0h", out_data, exp_v); else passed++;
                end
            end
            tick();
            if (idx == 2 && exp_q.size() == 0) break;
        end
        in_valid = 1'b0;
        total++; if (n_out !== 2) $display("FAIL rstmid_count_out: got %0d want 2", n_out); else passed++;
    endtask

    task automatic test_depth1;
        logic [W-1:0] want;
        o_out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            o_in_valid = (i < 4);
            o_in_data  = 32'h50 + 32'(i);
            @(negedge clk);
            total++; if (o_in_ready !== 1'b1) $display("FAIL d1_in_ready: got %0b want 1", o_in_ready); else passed++;
            if (i >= 1 && i <= 4) begin
                want = 32'h50 + 32'(i - 1);
                total++; if (o_out_valid !== 1'b1 || o_out_data !== want) $display("FAIL d1_out: got ov=%0b %0h want 1 %0h", o_out_valid, o_out_data, want); else passed++;
            end else begin
                total++; if (o_out_valid !== 1'b0) $display("FAIL d1_idle: got %0b want 0", o_out_valid); else passed++;
            end
            tick();
        end
        o_out_ready = 1'b0;
        o_in_valid  = 1'b1;
        o_in_data   = 32'h77;
        tick();
        o_in_valid = 1'b0;
        total++; if (o_out_valid !== 1'b1 || o_count !== 1'b1 || o_in_ready !== 1'b0) $display("FAIL d1_held: got ov=%0b cnt=%0d ir=%0b want 1/1/0", o_out_valid, o_count, o_in_ready); else passed++;
        o_flush = 1'b1;
        #1;
        total++; if (o_out_valid !== 1'b0 || o_in_ready !== 1'b1) $display("FAIL d1_flush_comb: got ov=%0b ir=%0b want 0/1", o_out_valid, o_in_ready); else passed++;
        tick();
        o_flush = 1'b0;
        total++; if (o_count !== 1'b0 || o_out_valid !== 1'b0) $display("FAIL d1_flushed: got cnt=%0d ov=%0b want 0/0", o_count, o_out_valid); else passed++;
    endtask

    initial begin
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = '0;
        out_ready   = 1'b0;
        flush       = '0;
        freeze      = 1'b0;
        o_in_valid  = 1'b0;
        o_in_data   = '0;
        o_out_ready = 1'b0;
        o_flush     = '0;
        o_freeze    = 1'b0;
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_freeze();
        test_reset_midstream();
        test_depth1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/stage_pipeline.md
STAGE_PIPELINE -- requirements
Module: stage_pipeline

Interface
REQ-001 Parameter WIDTH, default 32, payload width in bits (PC or instruction word per entry); legal range 1..64.
REQ-002 Parameter DEPTH, default 4, number of pipeline stages; legal range 1..16.
REQ-003 Parameter CW, default $clog2(DEPTH+1), width of the occupancy count.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  upstream offers in_data this cycle.
REQ-007 in_data  input  WIDTH  upstream payload.
REQ-008 in_ready  output  1  stage 0 accepts this cycle; transfer when in_valid & in_ready.
REQ-009 out_valid  output  1  stage DEPTH-1 presents a live entry.
REQ-010 out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-011 out_ready  input  1  downstream accepts; transfer when out_valid & out_ready.
REQ-012 flush  input  DEPTH  bit k kills the entry in stage k this cycle.
REQ-013 freeze  input  1  global stall; holds every stage.
REQ-014 count  output  CW  number of valid stages (registered valid bits).

Function
REQ-015 Each stage k (0 = input side, DEPTH-1 = output side) holds a valid bit v[k] and data register d[k].
REQ-016 Live valid: lv[k] = v[k] & ~flush[k]; killed entries are never passed on or output.
REQ-017 Advance enables: adv[DEPTH] = out_ready & ~freeze; adv[k] = ~freeze & (~lv[k] | adv[k+1]); all combinational.
REQ-018 in_ready = adv[0]; out_valid = lv[DEPTH-1] & ~freeze; out_data = d[DEPTH-1].
REQ-019 On a rising edge with adv[k]=1: v[k] loads source valid (in_valid for k=0, lv[k-1] otherwise); d[k] loads source data only if source valid, otherwise d[k] holds.
REQ-020 On a rising edge with adv[k]=0: v[k] <= lv[k] (flush clears the bit), d[k] holds.
REQ-021 Flush and freeze together: flushed stages still clear at the edge; all other state holds.
REQ-022 A flushed stage may accept a new entry on the same edge (branch redirect refills without bubble).
REQ-023 Throughput: one entry per cycle when out_ready=1, freeze=0, no flush.
REQ-024 Latency: entry accepted at edge n appears on out_valid after edge n+DEPTH-1 into an empty, unstalled pipe (DEPTH cycles from acceptance to output transfer).
REQ-025 Back-pressure: with out_ready=0, stages fill bubble-first from the output end; in_ready drops only when all DEPTH stages are live.
REQ-026 Order preserved; no entry duplicated or dropped except by flush.
REQ-027 count = popcount(v) from registers, range 0..DEPTH; updates one cycle after the causing edge's inputs.
REQ-028 in_valid while in_ready=0 has no effect; upstream holds in_data.

Reset
REQ-029 rst=1 asynchronously clears all v[k] and d[k] to 0 regardless of clk.
REQ-030 During and after reset until the next event: out_valid=0, out_data=0, count=0, in_ready = ~freeze.
REQ-031 Reset mid-operation discards all in-flight entries; no entry emerges after deassertion unless newly accepted.
REQ-032 Reset deassertion is asynchronous to the design; first capture on the first rising edge with rst=0.

Verification (DEPTH=4, WIDTH=32)
REQ-033 Stream 0x100,0x104,0x108 on consecutive cycles, out_ready=1 -> out_data 0x100,0x104,0x108 on consecutive cycles, first 4 cycles after acceptance; count peaks at 3.
REQ-034 out_ready=0, feed 6 entries -> 4 accepted, in_ready=0, count=4; raise out_ready -> 4 entries out in order, then remaining 2.
REQ-035 Pipe full 0xA0..0xAC (stage 0=0xAC), pulse flush=4'b0011 one cycle with in_valid=1 data 0xB0 -> 0xA8,0xAC lost, stage 0 holds 0xB0, count=3; output order 0xA0,0xA4,0xB0.
REQ-036 freeze=1 for 3 cycles mid-stream -> in_ready=0, out_valid=0, count constant; on release stream resumes without loss or duplication.
REQ-037 Assert rst asynchronously between edges with count=3 -> out_valid and count 0 immediately; after release, first output is the first entry accepted post-reset.
REQ-038 DEPTH=1 build: in->out latency 1 cycle, full throughput with out_ready=1, flush[0] kills the held entry.
